// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states and forwarding selects.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, REDIRECT} hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX operand forwarding compare; one lane per EX source operand.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int XLEN_RA = 5
) (
  input  logic [XLEN_RA-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic [XLEN_RA-1:0] wb_rd,
  input  logic               wb_reg_write,
  input  logic [XLEN_RA-1:0] ex_rs1,
  input  logic [XLEN_RA-1:0] ex_rs2,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][XLEN_RA-1:0] src;
  logic [NUM_SRC-1:0][1:0]         sel;

  assign src       = {ex_rs2, ex_rs1};
  assign fwd_a_sel = sel[0];
  assign fwd_b_sel = sel[1];

  // x0 is hardwired zero and never a forwarding source.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign sel[i] = fwd_pick(mem_reg_write && (mem_rd != '0) && (mem_rd == src[i]),
                             wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src[i]));
  end
endmodule

// File: rtl/opcodes.v
// RV32I major-opcode macros (instr[6:0]) shared by decode and hazard logic.
`ifndef OPCODES_V
`define OPCODES_V
`define OPC_LOAD    7'b0000011
`define OPC_I_TYPE  7'b0010011
`define OPC_AUIPC   7'b0010111
`define OPC_STORE   7'b0100011
`define OPC_R_TYPE  7'b0110011
`define OPC_LUI     7'b0110111
`define OPC_BRANCH  7'b1100011
`define OPC_JALR    7'b1100111
`define OPC_JAL     7'b1101111
`endif

// File: rtl/hazard_ctrl.sv
// Load-use / redirect stall-flush sequencer plus EX forwarding selects.
// Optional HAZARD_PERF_EN adds stall_cnt / flush_cnt performance counters.
`include "opcodes.v"

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int XLEN_RA          = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic               ex_valid,
  input  logic [XLEN_RA-1:0] ex_rd,
  input  logic               ex_is_load,
  input  logic               ex_redirect,
  input  logic [XLEN_RA-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic [XLEN_RA-1:0] wb_rd,
  input  logic               wb_reg_write,
  input  logic [XLEN_RA-1:0] ex_rs1,
  input  logic [XLEN_RA-1:0] ex_rs2,
  output logic               stall_if,
  output logic               stall_id,
  output logic               flush_id,
  output logic               flush_ex,
`ifdef HAZARD_PERF_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel
);
  localparam logic [2:0] CNT_RELOAD = 3'(REDIRECT_BUBBLES - 1);

  hz_state_e    state, state_n;
  logic [2:0]   cnt, cnt_n;
  logic         uses_rs1, uses_rs2, load_use;
  logic [XLEN_RA-1:0] rs1, rs2;
  logic         unused_instr;

  assign rs1          = id_instr[15 +: XLEN_RA];
  assign rs2          = id_instr[20 +: XLEN_RA];
  assign unused_instr = ^{id_instr[31:25], id_instr[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instr[6:0])
      `OPC_R_TYPE, `OPC_STORE, `OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      `OPC_I_TYPE, `OPC_JALR, `OPC_LOAD: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Redirect outranks load-use: the stalled instruction is wrong-path anyway.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    case (state)
      RUN: begin
        if (ex_redirect) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_n = REDIRECT;
            cnt_n   = CNT_RELOAD;
          end
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          state_n  = LU_STALL;
        end
      end
      // Load has moved to MEM and will be forwarded; EX is a bubble.
      LU_STALL: state_n = RUN;
      REDIRECT: begin
        flush_id = 1'b1;
        if (ex_redirect) begin
          cnt_n = CNT_RELOAD;
        end else if (cnt <= 3'd1) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_id) stall_cnt <= stall_cnt + 32'd1;
      if (flush_id) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  hazard_fwd_unit #(.XLEN_RA(XLEN_RA)) u_fwd (
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel)
  );
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Decodes the ID-stage instruction's register usage from opcode, detects load-use and control hazards, and sequences stall/flush of the IF/ID and ID/EX registers.
- Drives operand forwarding selects for EX.
- Sits beside the decode stage (immediate/control decode) and is shared by the IF, ID and EX pipeline registers.

Parameters:
- REDIRECT_BUBBLES, 1, cycles flush_id is held after a taken branch/jump redirect (instruction-memory latency); legal 1..7
- XLEN_RA, 5, register-address width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_instr  in  32  ID-stage instruction word
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX instruction is OPC_LOAD
- ex_redirect  in  1  EX resolved taken branch/JAL/JALR
- mem_rd  in  5  MEM destination; mem_reg_write in 1  MEM writes rd
- wb_rd  in  5  WB destination; wb_reg_write in 1  WB writes rd
- ex_rs1, ex_rs2  in  5 each  EX source registers (for forwarding)
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_id  out  1  bubble IF/ID
- flush_ex  out  1  bubble ID/EX
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 MEM result, 10 WB result, 11 never driven

Behaviour:
- Clock clk, synchronous active-high rst; all state updates on rising clk.
- Usage decode from id_instr[6:0] using opcodes.v macros:
  - uses_rs1 for OPC_R_TYPE, OPC_I_TYPE, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH.
  - uses_rs2 for OPC_R_TYPE, OPC_STORE, OPC_BRANCH.
  - LUI/AUIPC/JAL/unknown use neither.
  - rs1 = instr[19:15], rs2 = instr[24:20].
- load_use = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- FSM states:
  - RUN:
    - ex_redirect -> flush_id=1, flush_ex=1, stall=0; if REDIRECT_BUBBLES>1 go REDIRECT with cnt=REDIRECT_BUBBLES-1, else stay RUN.
    - else load_use -> stall_if=1, stall_id=1, flush_ex=1; go LU_STALL.
    - else all control outputs 0.
  - LU_STALL: exactly one cycle; outputs 0 (load now in MEM, forwarded); load_use is not re-evaluated; -> RUN. ex_redirect here is impossible (EX is a bubble) and is ignored.
  - REDIRECT: flush_id=1, others 0; cnt decrements; -> RUN when cnt reaches 1 (in that cycle flush_id still 1). A new ex_redirect restarts cnt=REDIRECT_BUBBLES-1.
- Priority: redirect > load-use. A simultaneous redirect and load_use produces flush only, no stall.
- Control outputs are combinational from state + inputs; state and cnt are registered.
- Forwarding (pure combinational, independent of FSM):
  - fwd_a_sel=01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1;
  - else 10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - fwd_b_sel likewise on ex_rs2. MEM has priority over WB.
- Reset: state=RUN, cnt=0. Outputs then follow inputs combinationally; with all inputs 0 every output is 0. Reset mid-REDIRECT or mid-LU_STALL abandons the sequence with no residual flush.
- x0 is never a hazard or forward source.

Optional Feature:
- HAZARD_PERF_EN:
  - Defined: adds ports stall_cnt out 32 and flush_cnt out 32, reset to 0.
  - stall_cnt increments each cycle stall_id=1; flush_cnt increments each cycle flush_id=1.
  - Both wrap at 2^32 and hold on rst.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: FSM state enum (RUN, LU_STALL, REDIRECT), fwd select constants (FWD_RF, FWD_MEM, FWD_WB).
- Opcode macros stay in opcodes.v; add OPC_R_TYPE there if absent.
- One natural sub-module, fwd_unit: the pure combinational forwarding compare, instantiated once.

Test Plan:
- Load-use: EX lw x5 (ex_is_load=1, ex_rd=5), ID add x6,x5,x7 (0x00728333) -> one cycle stall_if=stall_id=flush_ex=1, next cycle all 0, state RUN.
- No false stall: EX lw x5, ID lui x5,0x12345 (0x123452b7) -> no stall. Same with ex_rd=0 and ID using x0 -> no stall.
- Redirect with REDIRECT_BUBBLES=3: ex_redirect pulse -> cycle0 flush_id=flush_ex=1, cycles1-2 flush_id=1 only, cycle3 all 0. Second pulse in cycle1 restarts, giving flush_id through cycle3.
- Simultaneous ex_redirect and load_use -> flush_id=flush_ex=1, stall_if=0, no LU_STALL entry.
- Forwarding: mem_rd=wb_rd=ex_rs1=9, both write -> fwd_a_sel=01; mem_reg_write=0 -> 10; ex_rs2=0 with matching rd=0 -> fwd_b_sel=00.
- Reset asserted during REDIRECT (cnt=2) -> next cycle state RUN, flush_id=0. With HAZARD_PERF_EN, 4 stalls + 3 flushes -> stall_cnt=4, flush_cnt=3; rst -> both 0.
